// File: rtl/slow_memory_mc.sv
// slow_memory_mc: multi-channel slow main-memory model with round-robin
// arbitration, fixed access latency and a one-cycle ready pulse per request.
// All state advances on the falling clock edge; reset is asynchronous.
module slow_memory_mc #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 128,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 28,
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        mem_read,
    input  logic [NUM_CH-1:0]        mem_write,
    input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
    input  logic [NUM_CH*LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0]        mem_rdata,
    output logic [NUM_CH-1:0]        mem_ready,
    output logic                     mem_busy
);

    localparam int          CH_W  = (NUM_CH > 1)  ? $clog2(NUM_CH)  : 1;
    localparam int          IDX_W = (DEPTH > 1)   ? $clog2(DEPTH)   : 1;
    localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned NCH   = NUM_CH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } state_t;

    state_t             state;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    grant;
    logic [CNT_W-1:0]   cnt;
    logic               op_write;
    logic [IDX_W-1:0]   lat_idx;
    logic [LINE_W-1:0]  lat_wdata;
    logic [LINE_W-1:0]  mem [DEPTH];

    logic [NUM_CH-1:0]  eligible;
    logic               sel_valid;
    logic [CH_W-1:0]    sel_ch;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LINE_W-1:0]  sel_wdata;
    logic [CH_W-1:0]    rr_next;
    logic               addr_hi_unused;

    // A channel may be granted only when exactly one of read/write is asserted
    always_comb begin
        eligible = mem_read ^ mem_write;
    end

    // Round-robin pick: first eligible channel at or after the pointer, wrapping
    always_comb begin
        logic [CH_W-1:0] cand;
        sel_valid = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = CH_W'((32'(rr_ptr) + i) % NCH);
            if (!sel_valid && eligible[cand]) begin
                sel_valid = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    // Selected channel's address/data; only the low address bits index the array
    always_comb begin
        sel_addr       = mem_addr[sel_ch*ADDR_W +: ADDR_W];
        sel_wdata      = mem_wdata[sel_ch*LINE_W +: LINE_W];
        addr_hi_unused = ^sel_addr;
        rr_next        = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end

    // Control FSM with registered outputs; requests are sampled only in IDLE
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_ready <= '0;
            mem_rdata <= '0;
            mem_busy  <= 1'b0;
            rr_ptr    <= '0;
            cnt       <= '0;
            grant     <= '0;
            op_write  <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else begin
            mem_ready <= '0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant     <= sel_ch;
                        op_write  <= mem_write[sel_ch];
                        lat_idx   <= sel_addr[IDX_W-1:0];
                        lat_wdata <= sel_wdata;
                        cnt       <= CNT_W'(LATENCY - 1);
                        mem_busy  <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_ready[grant] <= 1'b1;
                        if (!op_write) begin
                            mem_rdata <= mem[lat_idx];
                        end
                        state <= READY;
                    end
                end
                READY: begin
                    rr_ptr   <= rr_next;
                    mem_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write on WAIT->READY; not reset, and an aborted access never reaches it
    always_ff @(negedge clk) begin
        if (state == WAIT && cnt == '0 && op_write) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_slow_memory_mc.sv
// Directed self-checking bench for slow_memory_mc: a default 2-channel
// instance plus two 4-channel instances at LATENCY=1 and LATENCY=16.
module tb_slow_memory_mc;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance: NUM_CH=2, LINE_W=128, DEPTH=1024, ADDR_W=28, LATENCY=4
    logic [1:0]   rd0, wr0;
    logic [55:0]  addr0;
    logic [255:0] wdata0;
    logic [127:0] rdata0;
    logic [1:0]   ready0;
    logic         busy0;

    // 4-channel instances share request inputs
    logic [3:0]   rd4, wr4;
    logic [31:0]  addr4;
    logic [127:0] wdata4;
    logic [31:0]  rdata1, rdata2;
    logic [3:0]   ready1, ready2;
    logic         busy1, busy2;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PAT5  = 128'h00112233445566778899AABBDEADBEEF;
    localparam logic [127:0] PATW  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PAT7A = 128'hA5A5A5A5_11110000_22220000_77777777;
    localparam logic [127:0] PAT7B = 128'h5A5A5A5A_33330000_44440000_88888888;
    localparam logic [127:0] JUNK  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    slow_memory_mc dut0 (
        .clk(clk), .rst(rst),
        .mem_read(rd0), .mem_write(wr0), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_rdata(rdata0), .mem_ready(ready0), .mem_busy(busy0)
    );

    slow_memory_mc #(.NUM_CH(4), .LINE_W(32), .DEPTH(16), .ADDR_W(8), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_read(rd4), .mem_write(wr4), .mem_addr(addr4), .mem_wdata(wdata4),
        .mem_rdata(rdata1), .mem_ready(ready1), .mem_busy(busy1)
    );

    slow_memory_mc #(.NUM_CH(4), .LINE_W(32), .DEPTH(16), .ADDR_W(8), .LATENCY(16)) dut2 (
        .clk(clk), .rst(rst),
        .mem_read(rd4), .mem_write(wr4), .mem_addr(addr4), .mem_wdata(wdata4),
        .mem_rdata(rdata2), .mem_ready(ready2), .mem_busy(busy2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on dut0 from an idle state; outputs sampled on rising edges.
    // n = samples until own ready, nb = samples with busy high, then one idle sample.
    task automatic req0(input int ch, input bit is_wr, input logic [27:0] a,
                        input logic [127:0] d, output int n, output int nb,
                        output logic [1:0] rdy, output logic [127:0] rdat,
                        output logic [1:0] rdy_after, output logic busy_after);
        rd0[ch] = !is_wr;
        wr0[ch] = is_wr;
        addr0[ch*28 +: 28]   = a;
        wdata0[ch*128 +: 128] = d;
        n  = 0;
        nb = 0;
        do begin
            @(posedge clk);
            n++;
            if (busy0) nb++;
        end while (!ready0[ch] && n < 100);
        rdy  = ready0;
        rdat = rdata0;
        rd0[ch] = 1'b0;
        wr0[ch] = 1'b0;
        @(posedge clk);
        rdy_after  = ready0;
        busy_after = busy0;
    endtask

    initial begin
        int n, nb, t1, t2, k0, k1, k2, idle_hits;
        logic [1:0]   rdy, rdy_after;
        logic         busy_after;
        logic [127:0] rdat;
        logic [1:0]   seq0 [4];
        logic [3:0]   seq1 [8];
        logic [3:0]   seq2 [8];
        logic [3:0]   e4;

        rst = 1'b1;
        rd0 = '0; wr0 = '0; addr0 = '0; wdata0 = '0;
        rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0;
        repeat (2) @(posedge clk);
        chk("reset_rdata", rdata0, '0);
        chk("reset_ready", ready0, '0);
        chk("reset_busy", busy0, '0);
        chk("reset_rdata_l1", rdata1, '0);
        chk("reset_busy_l16", busy2, '0);
        rst = 1'b0;
        @(posedge clk);

        // Preload line 5 through ch0
        req0(0, 1'b1, 28'd5, PAT5, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("wr5_latency", n, 5);
        chk("wr5_ready", rdy, 2'b01);
        chk("wr5_busy_cycles", nb, 5);
        chk("wr5_rdata_untouched", rdat, '0);
        chk("wr5_ready_falls", rdy_after, 2'b00);
        chk("wr5_busy_falls", busy_after, 1'b0);

        // Single read of line 5
        req0(0, 1'b0, 28'd5, '0, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("rd5_latency", n, 5);
        chk("rd5_ready", rdy, 2'b01);
        chk("rd5_rdata", rdat, PAT5);
        chk("rd5_ready_falls", rdy_after, 2'b00);

        // ch1 writes top line, ch0 reads it, ch1 reads the aliased address
        req0(1, 1'b1, 28'd1023, PATW, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("wr1023_ready", rdy, 2'b10);
        chk("wr1023_rdata_held", rdat, PAT5);
        req0(0, 1'b0, 28'd1023, '0, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("rd1023_rdata", rdat, PATW);
        req0(1, 1'b0, 28'd2047, '0, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("rd2047_alias_ready", rdy, 2'b10);
        chk("rd2047_alias_rdata", rdat, PATW);

        // Contention from reset: both read together, ch0 first then ch1
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        addr0 = {28'd1023, 28'd5};
        rd0 = 2'b11;
        n = 0;
        do begin @(posedge clk); n++; end while (ready0 == 2'b00 && n < 100);
        chk("cont_first_latency", n, 5);
        chk("cont_first_ready", ready0, 2'b01);
        chk("cont_first_rdata", rdata0, PAT5);
        rd0[0] = 1'b0;
        n = 0;
        do begin @(posedge clk); n++; end while (ready0 == 2'b00 && n < 100);
        chk("cont_second_ready", ready0, 2'b10);
        chk("cont_second_rdata", rdata0, PATW);
        rd0[1] = 1'b0;
        repeat (2) @(posedge clk);

        // Both held continuously: grants alternate 0,1,0,1
        rd0 = 2'b11;
        k0 = 0;
        for (int c = 0; c < 100 && k0 < 4; c++) begin
            @(posedge clk);
            if (ready0 != 2'b00) begin
                seq0[k0] = ready0;
                k0++;
            end
        end
        rd0 = 2'b00;
        chk("alt_count", k0, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt_grant%0d", k), seq0[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        repeat (4) @(posedge clk);

        // Read and write both high on ch0 is never granted
        addr0[27:0]   = 28'd5;
        wdata0[127:0] = JUNK;
        rd0 = 2'b01;
        wr0 = 2'b01;
        idle_hits = 0;
        repeat (20) begin
            @(posedge clk);
            if (busy0 || ready0 != 2'b00) idle_hits++;
        end
        rd0 = 2'b00;
        wr0 = 2'b00;
        chk("illegal_no_activity", idle_hits, 0);
        req0(0, 1'b0, 28'd5, '0, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("illegal_line5_kept", rdat, PAT5);

        // Reset two cycles into a write to line 7 aborts it
        req0(0, 1'b1, 28'd7, PAT7A, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("wr7_ready", rdy, 2'b01);
        addr0[55:28]    = 28'd7;
        wdata0[255:128] = PAT7B;
        wr0 = 2'b10;
        repeat (2) @(posedge clk);
        chk("abort_busy_before", busy0, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_rdata", rdata0, '0);
        chk("abort_ready", ready0, '0);
        @(posedge clk);
        wr0 = 2'b00;
        rst = 1'b0;
        @(posedge clk);
        req0(0, 1'b0, 28'd7, '0, n, nb, rdy, rdat, rdy_after, busy_after);
        chk("after_abort_latency", n, 5);
        chk("after_abort_line7", rdat, PAT7A);

        // Latency at the extremes: single ch2 read on both 4-channel instances
        addr4[23:16] = 8'd3;
        rd4 = 4'b0100;
        t1 = 0;
        t2 = 0;
        for (int c = 1; c <= 40 && (t1 == 0 || t2 == 0); c++) begin
            @(posedge clk);
            if (ready1[2] && t1 == 0) t1 = c;
            if (ready2[2] && t2 == 0) t2 = c;
        end
        rd4 = 4'b0000;
        chk("lat1_edges", t1, 2);
        chk("lat16_edges", t2, 17);
        repeat (20) @(posedge clk);

        // Full load from reset: each instance serves 0,1,2,3,0,1,2,3
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        rd4 = 4'b1111;
        k1 = 0;
        k2 = 0;
        for (int c = 0; c < 300 && (k1 < 8 || k2 < 8); c++) begin
            @(posedge clk);
            if (ready1 != 4'b0000 && k1 < 8) begin seq1[k1] = ready1; k1++; end
            if (ready2 != 4'b0000 && k2 < 8) begin seq2[k2] = ready2; k2++; end
        end
        rd4 = 4'b0000;
        chk("load_l1_count", k1, 8);
        chk("load_l16_count", k2, 8);
        for (int k = 0; k < 8; k++) begin
            e4 = 4'b0001 << (k % 4);
            chk($sformatf("load_l1_grant%0d", k), seq1[k], e4);
            chk($sformatf("load_l16_grant%0d", k), seq2[k], e4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
